// File: rtl/sel_mux_pkg.sv
// Shared types and constants for the select-mux pipeline stage.
package sel_mux_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    localparam int unsigned ERR_CNT_W   = 8;
    localparam int unsigned ERR_CNT_MAX = 255;
    localparam int unsigned DATA_W      = 32;

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush; in_ready comes from
// registered state only, so there is no combinational path from out_ready.
module skid_buf
    import sel_mux_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             rdy_q;
    logic             vld_q;
    logic             acc;
    logic             xfer;

    assign acc  = in_valid & rdy_q;
    assign xfer = vld_q & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else if (flush) begin
            // Any beat offered this cycle is dropped; a concurrent transfer still completes.
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_q  <= in_data;
                        state_q <= ONE;
                        vld_q   <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && !xfer) begin
                        skid_q  <= in_data;
                        state_q <= TWO;
                        rdy_q   <= 1'b0;
                    end else if (acc && xfer) begin
                        main_q <= in_data;
                    end else if (xfer) begin
                        state_q <= EMPTY;
                        vld_q   <= 1'b0;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    rdy_q   <= 1'b1;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_data  = main_q;

endmodule

// File: rtl/sel_mux_pipe.sv
// N-input select mux feeding a registered skid-buffered output stage.
// Define SEL_MUX_RANGE_CHECK_EN to zero out-of-range selects and count them.
module sel_mux_pipe
    import sel_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = DATA_W,
    parameter  int unsigned N     = 4,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0]      mux_data;
    logic [WIDTH+SELW-1:0] buf_out;

`ifdef SEL_MUX_RANGE_CHECK_EN
    logic sel_oor;
    assign sel_oor = 32'(in_sel) >= N;
`endif

    // Unmatched codes fall back to input 0 unless range checking forces zero.
    always_comb begin
        mux_data = in_data[WIDTH-1:0];
        for (int k = 1; k < N; k++) begin
            if (in_sel == SELW'(k)) begin
                mux_data = in_data[k*WIDTH +: WIDTH];
            end
        end
`ifdef SEL_MUX_RANGE_CHECK_EN
        if (sel_oor) begin
            mux_data = '0;
        end
`endif
    end

    skid_buf #(
        .WIDTH(WIDTH + SELW)
    ) u_skid_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_data  ({mux_data, in_sel}),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (buf_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out_data = buf_out[WIDTH+SELW-1:SELW];
    assign out_sel  = buf_out[SELW-1:0];

`ifdef SEL_MUX_RANGE_CHECK_EN
    logic                 accept;
    logic                 sticky_q;
    logic [ERR_CNT_W-1:0] cnt_q;

    // Beats dropped by flush never count as accepted.
    assign accept = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept && sel_oor) begin
            sticky_q <= 1'b1;
            if (cnt_q != ERR_CNT_W'(ERR_CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;
`else
    assign err_sticky = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Bench for sel_mux_pipe: directed N=4 checks plus a queue-model-checked N=3 instance.
module tb_sel_mux_pipe;

`ifdef SEL_MUX_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // N=3 instance (model-checked)
    logic [95:0] d3_in_data = '0;
    logic [1:0]  d3_sel = '0;
    logic        d3_valid = 1'b0, d3_flush = 1'b0, d3_out_ready = 1'b0;
    logic        d3_in_ready, d3_out_valid, d3_err_sticky;
    logic [31:0] d3_out_data;
    logic [1:0]  d3_out_sel;
    logic [7:0]  d3_err_cnt;

    // N=4 instance (directed)
    logic [127:0] d4_in_data = '0;
    logic [1:0]   d4_sel = '0;
    logic         d4_valid = 1'b0, d4_flush = 1'b0, d4_out_ready = 1'b0;
    logic         d4_in_ready, d4_out_valid, d4_err_sticky;
    logic [31:0]  d4_out_data;
    logic [1:0]   d4_out_sel;
    logic [7:0]   d4_err_cnt;

    sel_mux_pipe #(.WIDTH(32), .N(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(d3_in_data), .in_sel(d3_sel), .in_valid(d3_valid),
        .in_ready(d3_in_ready), .flush(d3_flush), .out_data(d3_out_data),
        .out_sel(d3_out_sel), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .err_sticky(d3_err_sticky), .err_cnt(d3_err_cnt)
    );

    sel_mux_pipe #(.WIDTH(32), .N(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(d4_in_data), .in_sel(d4_sel), .in_valid(d4_valid),
        .in_ready(d4_in_ready), .flush(d4_flush), .out_data(d4_out_data),
        .out_sel(d4_out_sel), .out_valid(d4_out_valid), .out_ready(d4_out_ready),
        .err_sticky(d4_err_sticky), .err_cnt(d4_err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_mux3(input logic [95:0] d, input logic [1:0] s);
        int idx;
        idx = int'(s);
        if (idx < 3) return d[idx*32 +: 32];
        return RC ? 32'h0 : d[31:0];
    endfunction

    // Reference model: FIFO of at most two beats, plus error counters.
    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } beat_t;
    beat_t q[$];
    int    m_cnt = 0;
    bit    m_sticky = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_cnt    = 0;
                m_sticky = 1'b0;
            end else begin
                bit    acc;
                bit    xfer;
                beat_t b;
                acc  = d3_valid && (q.size() < 2) && !d3_flush;
                xfer = (q.size() > 0) && d3_out_ready;
                b.d  = exp_mux3(d3_in_data, d3_sel);
                b.s  = d3_sel;
                if (xfer) void'(q.pop_front());
                if (d3_flush) q.delete();
                else if (acc) q.push_back(b);
                if (RC && acc && d3_sel == 2'd3) begin
                    m_sticky = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    end

    // Compare process for the N=3 instance.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                chk("cmp_in_ready", 32'(d3_in_ready), 32'(q.size() < 2));
                chk("cmp_out_valid", 32'(d3_out_valid), 32'(q.size() > 0));
                chk("cmp_err_sticky", 32'(d3_err_sticky), 32'(m_sticky));
                chk("cmp_err_cnt", 32'(d3_err_cnt), 32'(m_cnt));
                if (q.size() > 0) begin
                    chk("cmp_out_data", d3_out_data, q[0].d);
                    chk("cmp_out_sel", 32'(d3_out_sel), 32'(q[0].s));
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_valid4", 32'(d4_out_valid), 0);
        chk("rst_data4", d4_out_data, 0);
        chk("rst_sel4", 32'(d4_out_sel), 0);
        chk("rst_ready4", 32'(d4_in_ready), 1);
        chk("rst_sticky3", 32'(d3_err_sticky), 0);
        chk("rst_cnt3", 32'(d3_err_cnt), 0);
        chk("rst_ready3", 32'(d3_in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Streaming select sequence 0..3 at full throughput.
        d4_in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
        d4_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("fwd_data", d4_out_data, 32'(i * 17));
                chk("fwd_sel", 32'(d4_out_sel), 32'(i - 1));
                chk("fwd_valid", 32'(d4_out_valid), 1);
                chk("fwd_ready", 32'(d4_in_ready), 1);
            end
            if (i < 4) begin
                d4_valid = 1'b1;
                d4_sel   = 2'(i);
            end else begin
                d4_valid = 1'b0;
            end
        end

        // Backpressure: two beats held, then drained in order.
        @(negedge clk);
        chk("bp_idle", 32'(d4_out_valid), 0);
        d4_out_ready = 1'b0;
        d4_valid     = 1'b1;
        d4_sel       = 2'd1;
        @(negedge clk);
        chk("bp_ready1", 32'(d4_in_ready), 1);
        chk("bp_data1", d4_out_data, 32'h22);
        d4_sel = 2'd2;
        @(negedge clk);
        chk("bp_ready0", 32'(d4_in_ready), 0);
        chk("bp_hold", d4_out_data, 32'h22);
        chk("bp_hold_v", 32'(d4_out_valid), 1);
        d4_valid     = 1'b0;
        d4_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_next", d4_out_data, 32'h33);
        chk("bp_next_sel", 32'(d4_out_sel), 2);
        chk("bp_ready_back", 32'(d4_in_ready), 1);
        @(negedge clk);
        chk("bp_drained", 32'(d4_out_valid), 0);

        // Flush while full with a beat on offer.
        d4_out_ready = 1'b0;
        d4_valid     = 1'b1;
        d4_sel       = 2'd0;
        @(negedge clk);
        d4_sel = 2'd3;
        @(negedge clk);
        chk("fl_full", 32'(d4_in_ready), 0);
        chk("fl_main", d4_out_data, 32'h11);
        d4_flush = 1'b1;
        d4_sel   = 2'd1;
        @(negedge clk);
        chk("fl_valid", 32'(d4_out_valid), 0);
        chk("fl_ready", 32'(d4_in_ready), 1);
        d4_flush     = 1'b0;
        d4_valid     = 1'b0;
        d4_out_ready = 1'b1;
        @(negedge clk);
        chk("fl_dropped", 32'(d4_out_valid), 0);
        chk("fl_errcnt4", 32'(d4_err_cnt), 0);

        // Asynchronous reset while holding one beat.
        d4_out_ready = 1'b0;
        d4_valid     = 1'b1;
        d4_sel       = 2'd2;
        d3_in_data   = {32'hCCC2, 32'hBBB1, 32'hAAA0};
        d3_out_ready = 1'b0;
        d3_valid     = 1'b1;
        d3_sel       = 2'd1;
        @(negedge clk);
        chk("ar_before", d4_out_data, 32'h33);
        chk("ar_before_v", 32'(d4_out_valid), 1);
        d4_valid = 1'b0;
        d3_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_valid4", 32'(d4_out_valid), 0);
        chk("ar_data4", d4_out_data, 0);
        chk("ar_sel4", 32'(d4_out_sel), 0);
        chk("ar_valid3", 32'(d3_out_valid), 0);
        chk("ar_data3", d3_out_data, 0);
        @(negedge clk);
        rst          = 1'b0;
        d4_out_ready = 1'b1;
        d3_out_ready = 1'b1;

        // Out-of-range select on N=3, three accepts.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("oor_data", d3_out_data, RC ? 32'h0 : 32'hAAA0);
                chk("oor_sel", 32'(d3_out_sel), 3);
                chk("oor_valid", 32'(d3_out_valid), 1);
            end
            if (i == 3) begin
                chk("oor_cnt", 32'(d3_err_cnt), RC ? 32'd3 : 32'd0);
                chk("oor_sticky", 32'(d3_err_sticky), RC ? 32'd1 : 32'd0);
            end
            d3_valid = (i < 3);
            d3_sel   = 2'd3;
        end

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            d3_valid     = ($urandom_range(0, 3) != 0);
            d3_sel       = 2'($urandom_range(0, 3));
            d3_in_data   = {$urandom(), $urandom(), $urandom()};
            d3_out_ready = ($urandom_range(0, 2) != 0);
            d3_flush     = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        d3_valid     = 1'b0;
        d3_flush     = 1'b0;
        d3_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Saturation: 300 out-of-range accepts, then a flush.
        d3_valid = 1'b1;
        d3_sel   = 2'd3;
        for (int i = 0; i < 300; i++) @(negedge clk);
        d3_valid = 1'b0;
        @(negedge clk);
        chk("sat_cnt", 32'(d3_err_cnt), RC ? 32'd255 : 32'd0);
        d3_flush = 1'b1;
        @(negedge clk);
        d3_flush = 1'b0;
        @(negedge clk);
        chk("sat_sticky", 32'(d3_err_sticky), RC ? 32'd1 : 32'd0);
        chk("sat_cnt_kept", 32'(d3_err_cnt), RC ? 32'd255 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
